// File: rtl/timer_dev.sv
// ---------------------------------------------------------------------------
// timer_dev -- memory-mapped down-counting timer with interrupt request.
//
// Register map (Addr_I):
//   0 CTRL   : bit0 EN, bits2:1 MODE, bit3 IM (upper bits read as 0)
//   1 PRESET : 32-bit reload value
//   2 COUNT  : 32-bit current count, read-only
//   3 reserved, reads 0
//
// Ports:
//   clk    : sole clock, rising-edge
//   reset  : asynchronous, active-high; clears all state
//   Addr_I : register select (processor address bits [5:4])
//   WE_I   : write strobe, sampled on the clk rising edge
//   WD_I   : write data
//   RD_O   : read data, combinational from Addr_I
//   IRQ_O  : interrupt request = irq_pend & IM
//
// Operation: IDLE -> LOAD (COUNT <= PRESET) -> CNT (decrement) -> INT.
// MODE 1 reloads and counts again (IRQ_O is a one-cycle pulse); every other
// MODE is one-shot: EN is cleared in INT and the interrupt stays pending
// until software writes CTRL or PRESET.
// ---------------------------------------------------------------------------
module timer_dev (
   input  logic        clk,
   input  logic        reset,
   input  logic [1:0]  Addr_I,
   input  logic        WE_I,
   input  logic [31:0] WD_I,
   output logic [31:0] RD_O,
   output logic        IRQ_O
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_CNT  = 2'd2,
      ST_INT  = 2'd3
   } state_t;

   state_t      state_r;
   state_t      next_state_s;

   logic        ctrl_en_r;
   logic [1:0]  ctrl_mode_r;
   logic        ctrl_im_r;
   logic [31:0] preset_r;
   logic [31:0] count_r;
   logic        irq_pend_r;

   logic        wr_ctrl_s;
   logic        wr_preset_s;
   logic [31:0] count_next_s;
   logic        hw_en_clr_s;
   logic        irq_set_s;
   logic        irq_leave_clr_s;

   // Decode register writes from the bus strobe and address.
   always_comb begin
      wr_ctrl_s   = 1'b0;
      wr_preset_s = 1'b0;
      if (WE_I) begin
         wr_ctrl_s   = (Addr_I == 2'd0);
         wr_preset_s = (Addr_I == 2'd1);
      end else begin
         wr_ctrl_s   = 1'b0;
         wr_preset_s = 1'b0;
      end
   end

   // Next-state, next-count and interrupt/EN side effects of the FSM.
   // Decisions use the registered EN, so a CTRL write acts one cycle later.
   always_comb begin
      next_state_s    = state_r;
      count_next_s    = count_r;
      hw_en_clr_s     = 1'b0;
      irq_set_s       = 1'b0;
      irq_leave_clr_s = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (ctrl_en_r) begin
               next_state_s = ST_LOAD;
            end else begin
               next_state_s = ST_IDLE;
            end
         end
         ST_LOAD: begin
            count_next_s = preset_r;
            next_state_s = ST_CNT;
         end
         ST_CNT: begin
            if (!ctrl_en_r) begin
               next_state_s = ST_IDLE;
            end else if (count_r <= 32'd1) begin
               // Covers PRESET 0 and 1 alike and keeps COUNT from wrapping.
               count_next_s = 32'd0;
               next_state_s = ST_INT;
               irq_set_s    = 1'b1;
            end else begin
               count_next_s = count_r - 32'd1;
               next_state_s = ST_CNT;
            end
         end
         ST_INT: begin
            if (ctrl_mode_r == 2'd1) begin
               next_state_s    = ST_LOAD;
               irq_leave_clr_s = 1'b1;
            end else begin
               next_state_s = ST_IDLE;
               hw_en_clr_s  = 1'b1;
            end
         end
         default: begin
            next_state_s = ST_IDLE;
         end
      endcase
   end

   // FSM state and COUNT registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r <= ST_IDLE;
         count_r <= 32'd0;
      end else begin
         state_r <= next_state_s;
         count_r <= count_next_s;
      end
   end

   // CTRL register; a software write wins over the hardware EN clear.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ctrl_en_r   <= 1'b0;
         ctrl_mode_r <= 2'd0;
         ctrl_im_r   <= 1'b0;
      end else if (wr_ctrl_s) begin
         ctrl_en_r   <= WD_I[0];
         ctrl_mode_r <= WD_I[2:1];
         ctrl_im_r   <= WD_I[3];
      end else if (hw_en_clr_s) begin
         ctrl_en_r   <= 1'b0;
      end
   end

   // PRESET register; only sampled in LOAD, so mid-count writes wait.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         preset_r <= 32'd0;
      end else if (wr_preset_s) begin
         preset_r <= WD_I;
      end
   end

   // Interrupt pending flag: set on entering INT, cleared by a CTRL/PRESET
   // write or by leaving INT in auto-reload mode.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         irq_pend_r <= 1'b0;
      end else if (irq_set_s) begin
         irq_pend_r <= 1'b1;
      end else if (wr_ctrl_s || wr_preset_s || irq_leave_clr_s) begin
         irq_pend_r <= 1'b0;
      end
   end

   // Combinational read mux.
   always_comb begin
      RD_O = 32'd0;
      case (Addr_I)
         2'd0:    RD_O = {28'd0, ctrl_im_r, ctrl_mode_r, ctrl_en_r};
         2'd1:    RD_O = preset_r;
         2'd2:    RD_O = count_r;
         default: RD_O = 32'd0;
      endcase
   end

   assign IRQ_O = irq_pend_r & ctrl_im_r;

endmodule
